// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one RAM port between icache reads and dcache reads/writes
// Ports: CLK/nRST clock and async active-low reset; iREN/iaddr/iwait/iload icache side;
// dREN/dWEN/daddr/dstore/dwait/dload dcache side; ramREN/ramWEN/ramaddr/ramstore/ramload/ramready RAM side.
// IAGE: dcache completions seen with iREN pending before icache is forced the next grant.
module mem_arbiter #(
  parameter int IAGE = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);
  localparam logic [3:0] AGE_MAX = 4'(IAGE);
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  state_t     r_state;
  logic [3:0] r_age;
  logic       w_dreq, w_dcmp, w_icmp, w_ifirst;
  assign w_dreq   = dREN | dWEN;
  // a dropped request never completes, even if ramready happens to be high
  assign w_dcmp   = (r_state == DGRANT) && w_dreq && ramready;
  assign w_icmp   = (r_state == IGRANT) && iREN && ramready;
  assign w_ifirst = iREN && (r_age == AGE_MAX);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_age   <= '0;
    end else begin
      case (r_state)
        IDLE:    r_state <= (w_dreq && !w_ifirst) ? DGRANT : iREN ? IGRANT : IDLE;
        DGRANT:  r_state <= (!w_dreq || ramready) ? IDLE : DGRANT;
        IGRANT:  r_state <= (!iREN || ramready) ? IDLE : IGRANT;
        default: r_state <= IDLE;
      endcase
      if (!iREN || w_icmp)
        r_age <= '0;
      else if (w_dcmp && r_age != AGE_MAX)
        r_age <= r_age + 4'd1;
    end
  end
  // dREN with dWEN is a write, so the read enable is suppressed
  assign ramREN   = (r_state == DGRANT) ? (dREN & ~dWEN) : (r_state == IGRANT) ? iREN : 1'b0;
  assign ramWEN   = (r_state == DGRANT) & dWEN;
  assign ramaddr  = (r_state == DGRANT) ? daddr : (r_state == IGRANT) ? iaddr : '0;
  assign ramstore = (r_state == DGRANT) ? dstore : '0;
  assign dwait    = ~w_dcmp;
  assign iwait    = ~w_icmp;
  assign dload    = w_dcmp ? ramload : '0;
  assign iload    = w_icmp ? ramload : '0;
endmodule
